// File: rtl/time_set_ctrl.sv
// Clock timekeeping and time-setting controller: BCD H:M:S from a 1 Hz prescaler, mode FSM for setting fields.
// Optional build macro TIMESET_SECHOLD_EN freezes seconds/prescaler while a SET mode is active.
module time_set_ctrl #(
   parameter int DIV = 50000000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [2:0] BTN,
   output logic [7:0] HOUR,
   output logic [7:0] MIN,
   output logic [7:0] SEC,
   output logic [1:0] MODE,
   output logic       TICK
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } mode_t;

   localparam logic [25:0] CNT_TOP = 26'(DIV - 1);

   mode_t       state, state_nxt;
   logic [25:0] cnt, cnt_nxt;
   logic [2:0]  btn_q;
   logic [7:0]  hour_nxt, min_nxt, sec_nxt;
   logic        do_mode, do_clr, do_inc;
   logic        en1hz, freeze, tick_en, sec_wrap, min_wrap;
   logic        inc_hour, inc_min;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
      if (v == lim)
         bcd_inc = 8'h00;
      else if (v[3:0] == 4'd9)
         bcd_inc = {v[7:4] + 4'd1, 4'd0};
      else
         bcd_inc = {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Buttons are registered once; only the highest-priority bit of a cycle acts.
   assign do_mode = btn_q[0];
   assign do_clr  = btn_q[2] & ~btn_q[0];
   assign do_inc  = btn_q[1] & ~btn_q[0] & ~btn_q[2];

   always_ff @(posedge CLK) begin
      if (RST)
         state <= RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (do_mode) begin
         case (state)
            RUN:      state_nxt = SET_HOUR;
            SET_HOUR: state_nxt = SET_MIN;
            default:  state_nxt = RUN;
         endcase
      end
   end

   always_comb begin
      en1hz = (cnt == CNT_TOP);
`ifdef TIMESET_SECHOLD_EN
      freeze = (state != RUN) || (state_nxt != RUN);
`else
      freeze = 1'b0;
`endif
      tick_en  = en1hz & ~freeze;
      inc_hour = do_inc && (state == SET_HOUR);
      inc_min  = do_inc && (state == SET_MIN);

      cnt_nxt = (do_clr || en1hz || freeze) ? 26'd0 : cnt + 26'd1;

      sec_nxt = SEC;
      if (do_clr || freeze)
         sec_nxt = 8'h00;
      else if (tick_en)
         sec_nxt = bcd_inc(SEC, 8'h59);

      // A button edit on a field wins over the tick carry into it; that carry is lost.
      sec_wrap = tick_en && !do_clr && (SEC == 8'h59);
      min_wrap = sec_wrap && !inc_min && (MIN == 8'h59);

      min_nxt = MIN;
      if (inc_min || sec_wrap)
         min_nxt = bcd_inc(MIN, 8'h59);

      hour_nxt = HOUR;
      if (inc_hour || min_wrap)
         hour_nxt = bcd_inc(HOUR, 8'h23);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt   <= 26'd0;
         btn_q <= 3'b000;
         HOUR  <= 8'h00;
         MIN   <= 8'h00;
         SEC   <= 8'h00;
         TICK  <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         btn_q <= BTN;
         HOUR  <= hour_nxt;
         MIN   <= min_nxt;
         SEC   <= sec_nxt;
         TICK  <= tick_en;
      end
   end

   assign MODE = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with DIV=4; expected values are hand-computed from cycle counts.
module tb_time_set_ctrl;

   logic       CLK;
   logic       RST;
   logic [2:0] BTN;
   logic [7:0] HOUR, MIN, SEC;
   logic [1:0] MODE;
   logic       TICK;

   int n_chk  = 0;
   int n_fail = 0;

   time_set_ctrl #(.DIV(4)) dut (
      .CLK  (CLK),
      .RST  (RST),
      .BTN  (BTN),
      .HOUR (HOUR),
      .MIN  (MIN),
      .SEC  (SEC),
      .MODE (MODE),
      .TICK (TICK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive at negedge, pass one active edge, return at the next negedge.
   task automatic cyc(input logic [2:0] b);
      BTN = b;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic rep(input logic [2:0] b, input int n);
      for (int i = 0; i < n; i++) cyc(b);
   endtask

   // After this the prescaler is 0 and SEC is 00: ticks land on every 4th following edge.
   task automatic clr_sync();
      cyc(3'b100);
      cyc(3'b000);
   endtask

   logic [7:0] exp_sec;

   initial begin
      RST = 1'b1;
      BTN = 3'b000;
      @(negedge CLK);
      cyc(3'b000);
      cyc(3'b000);
      check("rst_hour", HOUR, 8'h00);
      check("rst_min",  MIN,  8'h00);
      check("rst_sec",  SEC,  8'h00);
      check("rst_mode", {6'd0, MODE}, 8'd0);
      check("rst_tick", {7'd0, TICK}, 8'd0);
      RST = 1'b0;

      // Free run: tick on every 4th edge, 240 edges give one minute.
      for (int k = 1; k <= 8; k++) begin
         cyc(3'b000);
         check("tick_pattern", {7'd0, TICK}, (k % 4 == 0) ? 8'd1 : 8'd0);
         if (k == 4) check("sec_at_first_tick", SEC, 8'h01);
      end
      rep(3'b000, 232);
      check("run_sec",  SEC,  8'h00);
      check("run_min",  MIN,  8'h01);
      check("run_hour", HOUR, 8'h00);
      check("run_tick", {7'd0, TICK}, 8'd1);

      // Set-mode walk: hour +25 wraps to 01, minute 01 +61 wraps to 02.
      clr_sync();
      cyc(3'b001);
      check("mode_latency", {6'd0, MODE}, 8'd0);
      cyc(3'b000);
      check("mode_set_hour", {6'd0, MODE}, 8'd1);
      rep(3'b010, 25);
      cyc(3'b000);
      check("hour_inc25", HOUR, 8'h01);
      check("hour_inc_min", MIN, 8'h01);
      cyc(3'b001);
      cyc(3'b000);
      check("mode_set_min", {6'd0, MODE}, 8'd2);
      rep(3'b010, 61);
      cyc(3'b000);
      check("min_inc61", MIN, 8'h02);
      check("min_inc_hour", HOUR, 8'h01);
      cyc(3'b001);
      cyc(3'b000);
      check("mode_run", {6'd0, MODE}, 8'd0);

      // All three buttons at once in RUN: only the mode step acts.
      clr_sync();
      cyc(3'b111);
      cyc(3'b000);
      check("prio_mode", {6'd0, MODE}, 8'd1);
      check("prio_sec",  SEC,  8'h00);
      check("prio_hour", HOUR, 8'h01);
      check("prio_min",  MIN,  8'h02);
      cyc(3'b001);
      cyc(3'b001);
      cyc(3'b000);
      check("prio_back_run", {6'd0, MODE}, 8'd0);

      // Preload 23:59, run to :58, then two ticks roll over to midnight.
      cyc(3'b001);
      cyc(3'b000);
      rep(3'b010, 22);
      cyc(3'b000);
      cyc(3'b001);
      cyc(3'b000);
      rep(3'b010, 57);
      cyc(3'b000);
      cyc(3'b001);
      cyc(3'b000);
      check("preload_hour", HOUR, 8'h23);
      check("preload_min",  MIN,  8'h59);
      clr_sync();
      rep(3'b000, 232);
      check("pre_sec58", SEC, 8'h58);
      rep(3'b000, 4);
      check("pre_sec59", SEC, 8'h59);
      check("pre_min59", MIN, 8'h59);
      rep(3'b000, 4);
      check("wrap_hour", HOUR, 8'h00);
      check("wrap_min",  MIN,  8'h00);
      check("wrap_sec",  SEC,  8'h00);

      // SEC=59 in SET_MIN with the increment landing on the tick edge.
      rep(3'b000, 236);
      check("coll_pre_sec", SEC, 8'h59);
      cyc(3'b001);
      cyc(3'b001);
      cyc(3'b010);
      cyc(3'b000);
      check("coll_mode", {6'd0, MODE}, 8'd2);
      check("coll_min",  MIN,  8'h01);
      check("coll_sec",  SEC,  8'h00);
      check("coll_hour", HOUR, 8'h00);
`ifdef TIMESET_SECHOLD_EN
      check("coll_tick", {7'd0, TICK}, 8'd0);
`else
      check("coll_tick", {7'd0, TICK}, 8'd1);
`endif

      // Build 12:34:56 in SET_MIN, then reset with a button pulse pending.
      rep(3'b010, 33);
      cyc(3'b000);
      check("set_min34", MIN, 8'h34);
      cyc(3'b001);
      cyc(3'b001);
      cyc(3'b000);
      rep(3'b010, 12);
      cyc(3'b000);
      cyc(3'b001);
      cyc(3'b000);
      clr_sync();
      rep(3'b000, 224);
`ifdef TIMESET_SECHOLD_EN
      exp_sec = 8'h00;
`else
      exp_sec = 8'h56;
`endif
      check("mid_hour", HOUR, 8'h12);
      check("mid_min",  MIN,  8'h34);
      check("mid_sec",  SEC,  exp_sec);
      check("mid_mode", {6'd0, MODE}, 8'd2);
      cyc(3'b010);
      RST = 1'b1;
      cyc(3'b000);
      check("mrst_hour", HOUR, 8'h00);
      check("mrst_min",  MIN,  8'h00);
      check("mrst_sec",  SEC,  8'h00);
      check("mrst_mode", {6'd0, MODE}, 8'd0);
      check("mrst_tick", {7'd0, TICK}, 8'd0);
      RST = 1'b0;
      cyc(3'b000);
      check("post_rst_min",  MIN, 8'h00);
      check("post_rst_mode", {6'd0, MODE}, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
